// File: rtl/frame_sync_inserter.sv
// Serial-line framer. Incoming encoded bits are buffered in a small bit FIFO
// and sent out as frames: a fixed sync word followed by a fixed-length
// payload. When the FIFO runs dry mid-payload, a constant fill bit is sent
// instead, so frame timing on the line never slips.
module frame_sync_inserter #(
  parameter int                  SYNC_LEN     = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 16'hEB90,
  parameter int                  PAYLOAD_LEN  = 56,
  parameter int                  FIFO_DEPTH   = 16,
  parameter int                  START_THRESH = 8,
  parameter logic                FILL_BIT     = 1'b0
) (
  input  logic        clk_out,
  input  logic        rst,
  input  logic        data_in,
  input  logic        data_valid,
  output logic        data_in_ready,
  output logic        data_out,
  output logic        data_out_valid,
  output logic        frame_start,
  output logic        underrun_err,
  output logic [15:0] frame_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(((SYNC_LEN > PAYLOAD_LEN) ? SYNC_LEN : PAYLOAD_LEN) + 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   THRESH_C  = (PTR_W+1)'(START_THRESH);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN);
  localparam logic [CNT_W-1:0] PL_LAST   = CNT_W'(PAYLOAD_LEN);

  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD} state_t;

  state_t              state, state_nxt;
  logic                mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic                wr_en, rd_en;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [SYNC_LEN-1:0] sync_sr, sync_sr_nxt;
  logic                out_nxt, vld_nxt, fs_nxt, under_nxt;
  logic [15:0]         fc_nxt;
  logic                start_frame, emit_payload;

  // Ready is held low during reset; a full FIFO never accepts, even when popping.
  assign data_in_ready = rst && (count < DEPTH_C);
  assign wr_en         = data_valid && data_in_ready;

  // FIFO pointers and occupancy; the pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; holds only data, so it needs no reset.
  always_ff @(posedge clk_out) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  // Next state and next line outputs. A frame start and a payload bit are
  // each reachable from two states, so they are flagged here and applied once below.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    sync_sr_nxt  = sync_sr;
    out_nxt      = 1'b0;
    vld_nxt      = 1'b0;
    fs_nxt       = 1'b0;
    under_nxt    = underrun_err;
    fc_nxt       = frame_count;
    rd_en        = 1'b0;
    start_frame  = 1'b0;
    emit_payload = 1'b0;

    case (state)
      IDLE: begin
        if (count >= THRESH_C) start_frame = 1'b1;
      end
      SYNC: begin
        if (bit_cnt == SYNC_LAST) begin
          state_nxt    = PAYLOAD;
          bit_cnt_nxt  = CNT_W'(1);
          emit_payload = 1'b1;
        end else begin
          out_nxt     = sync_sr[SYNC_LEN-1];
          vld_nxt     = 1'b1;
          sync_sr_nxt = sync_sr << 1;
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      PAYLOAD: begin
        if (bit_cnt == PL_LAST) begin
          // Last payload bit already went out; chain straight into the next frame if possible.
          if (count >= THRESH_C) start_frame = 1'b1;
          else                   state_nxt   = IDLE;
        end else begin
          emit_payload = 1'b1;
          bit_cnt_nxt  = bit_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start_frame) begin
      state_nxt   = SYNC;
      out_nxt     = SYNC_WORD[SYNC_LEN-1];
      vld_nxt     = 1'b1;
      fs_nxt      = 1'b1;
      sync_sr_nxt = SYNC_WORD << 1;
      bit_cnt_nxt = CNT_W'(1);
    end

    if (emit_payload) begin
      vld_nxt = 1'b1;
      rd_en   = (count != '0);
      out_nxt = rd_en ? mem[rd_ptr] : FILL_BIT;
      if (!rd_en) under_nxt = 1'b1;
      if (bit_cnt_nxt == PL_LAST) fc_nxt = frame_count + 16'd1;
    end
  end

  // FSM state and registered line outputs.
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      sync_sr        <= '0;
      data_out       <= 1'b0;
      data_out_valid <= 1'b0;
      frame_start    <= 1'b0;
      underrun_err   <= 1'b0;
      frame_count    <= '0;
    end else begin
      state          <= state_nxt;
      bit_cnt        <= bit_cnt_nxt;
      sync_sr        <= sync_sr_nxt;
      data_out       <= out_nxt;
      data_out_valid <= vld_nxt;
      frame_start    <= fs_nxt;
      underrun_err   <= under_nxt;
      frame_count    <= fc_nxt;
    end
  end

endmodule

// File: doc/frame_sync_inserter.md
Name: frame_sync_inserter

Overview:
Serial-line framer that pairs with the frame synchroniser. It takes the Hamming-encoded bit stream, buffers it in a small bit FIFO, and emits frames. Each frame is a fixed sync word followed by a fixed-length payload, and the result drives the channel/synchroniser input. Underruns are filled with a constant bit and flagged, so the receiver always sees correctly timed frames.

Parameters:
SYNC_LEN, 16, sync word length in bits
SYNC_WORD, 16'hEB90, sync pattern, sent MSB first
PAYLOAD_LEN, 56, payload bits per frame (8 x Hamming(7,4) codewords)
FIFO_DEPTH, 16, bit FIFO depth (power of 2)
START_THRESH, 8, FIFO occupancy needed to start a frame (1..FIFO_DEPTH)
FILL_BIT, 1'b0, bit emitted on payload underrun

Ports:
clk_out  input  1  bit clock; the single clock of the block
rst  input  1  asynchronous, active-low reset
data_in  input  1  encoded bit from upstream
data_valid  input  1  data_in valid
data_in_ready  output  1  FIFO can accept a bit
data_out  output  1  serial line bit
data_out_valid  output  1  line is carrying frame bits
frame_start  output  1  one-cycle pulse on the first sync bit of each frame
underrun_err  output  1  sticky flag: a fill bit was inserted
frame_count  output  16  frames completed, wraps at 65535->0

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty; FSM in IDLE.
  - data_out=0, data_out_valid=0, frame_start=0, underrun_err=0, frame_count=0.
  - data_in_ready=0 while in reset.
  - Reset mid-frame aborts the frame with no partial completion or count.
- FIFO:
  - data_in_ready = (count < FIFO_DEPTH), driven combinationally from the registered count.
  - Write occurs when data_valid && data_in_ready.
  - When full, no write happens even if a read occurs in the same cycle.
  - Simultaneous read and write when not full: count is unchanged and order is preserved.
  - Read pointer and write pointer wrap modulo FIFO_DEPTH.
- All line outputs are registered and updated on the rising edge of clk_out.
- FSM states: IDLE, SYNC, PAYLOAD; bit_cnt counter.
- IDLE:
  - data_out_valid=0, data_out=0.
  - If count >= START_THRESH, the next edge goes to SYNC and drives data_out=SYNC_WORD[SYNC_LEN-1], data_out_valid=1, frame_start=1, bit_cnt=1.
- SYNC:
  - Each edge emits SYNC_WORD[SYNC_LEN-1-bit_cnt] and increments bit_cnt.
  - frame_start=0.
  - After the last sync bit, the next edge enters PAYLOAD and emits the first payload bit.
  - The FIFO is not read during SYNC.
- PAYLOAD:
  - Each edge emits one bit.
  - If FIFO is non-empty, pop and emit the head bit.
  - If FIFO is empty, emit FILL_BIT and set underrun_err=1.
  - Exactly PAYLOAD_LEN bits are emitted; an underrun never shortens the frame.
- End of frame:
  - frame_count increments on the edge that emits the last payload bit.
  - On the following edge: if count >= START_THRESH, go SYNC with frame_start=1 (frames back-to-back, no gap). Otherwise go IDLE with data_out_valid=0.
  - The occupancy check uses the count value from before that edge.
- Latency: data_out_valid rises on the edge after the edge that writes the START_THRESH-th bit.
- Frame length: SYNC_LEN+PAYLOAD_LEN = 72 line cycles.
- Bit ordering: payload bits leave in exactly the order accepted. Each frame's payload bits are the next PAYLOAD_LEN accepted bits, with fill bits standing in for missing ones.
- underrun_err clears only on reset.

Test Plan:
1. Single frame, zero underrun. Reset, then push 56 bits 1/cycle with pattern 0x65D0703F_A5C3B1 (MSB first), then stop.
   -> data_out_valid rises 1 cycle after the 8th write.
   -> frame_start pulses once with the first sync bit.
   -> Line carries 1110101110010000 followed by the 56 pushed bits in order.
   -> frame_count=1, underrun_err=0, then IDLE.
2. Backpressure. Hold data_valid=1 continuously with 200 bits.
   -> data_in_ready drops whenever count=16.
   -> Frames are back-to-back with no gap.
   -> Every accepted bit appears exactly once, in order.
   -> frame_count increments every 72 cycles.
3. Underrun. Push only 8 bits, all ones.
   -> Line carries 16 sync bits, 8 ones, then 48 zeros.
   -> underrun_err=1, frame_count=1, then IDLE with data_out_valid=0.
4. Threshold edge. Push 7 bits.
   -> Stays IDLE with data_out_valid=0 indefinitely.
   -> The 8th bit triggers the frame start on the next edge.
5. Full/simultaneous. Fill the FIFO to 16 bits while the FSM is in PAYLOAD.
   -> Pops continue and data_in_ready reasserts the cycle after count<16.
   -> A write and a pop in the same cycle leave count unchanged.
6. Reset mid-payload. Assert rst=0 for 1 cycle at payload bit 30.
   -> All outputs go to 0 immediately (asynchronously), FIFO empty, frame_count=0.
   -> After release, a new push of 8 bits restarts a frame from sync bit 0.
